// File: rtl/nios_system_gpio_pkg.sv
// Shared constants for the bidirectional GPIO slave: register map, capture and
// interrupt mode selectors, and parameter legality helpers.
package nios_system_gpio_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_EDGE  = 1;

    localparam int BUS_WIDTH = 32;

    function automatic bit data_width_legal(input int w);
        return (w >= 1) && (w <= BUS_WIDTH);
    endfunction

    function automatic bit sync_stages_legal(input int s);
        return (s >= 2) && (s <= 4);
    endfunction

endpackage

// File: rtl/nios_system_gpio_bidir_if.sv
// Avalon-MM slave port bundle for the GPIO block; readdata is the only
// slave-driven signal.
interface nios_system_gpio_bidir_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/nios_system_gpio_sync.sv
// Input synchroniser, one-cycle delay for edge detection and a post-reset arm
// counter that masks edges until the synchroniser holds real pad data.
module nios_system_gpio_sync
    import nios_system_gpio_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] async_in,
    output logic [DATA_WIDTH-1:0] sync_out,
    output logic [DATA_WIDTH-1:0] edge_out
);

    localparam int ARM_COUNT = SYNC_STAGES + 1;
    localparam int CNT_W     = $clog2(ARM_COUNT + 1);
    localparam bit SEL_RISE  = (EDGE_TYPE != EDGE_FALL);
    localparam bit SEL_FALL  = (EDGE_TYPE != EDGE_RISE);

    logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] stage_q;
    logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] stage_d;
    logic [DATA_WIDTH-1:0]                  prev_q;
    logic [DATA_WIDTH-1:0]                  prev_d;
    logic [DATA_WIDTH-1:0]                  sync_in;
    logic [DATA_WIDTH-1:0]                  edge_raw;
    logic [CNT_W-1:0]                       arm_cnt_q;
    logic [CNT_W-1:0]                       arm_cnt_d;
    logic                                   armed;

    assign sync_in = stage_q[SYNC_STAGES-1];
    assign armed   = (arm_cnt_q == CNT_W'(ARM_COUNT));

    always_comb begin
        stage_d   = {stage_q[SYNC_STAGES-2:0], async_in};
        prev_d    = sync_in;
        arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + CNT_W'(1);
    end

    // Capture mode is folded into two constant selects so every bit uses the
    // same rise/fall terms regardless of EDGE_TYPE.
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_edge
        logic rise;
        logic fall;
        assign rise         = sync_in[gi] & ~prev_q[gi];
        assign fall         = ~sync_in[gi] & prev_q[gi];
        assign edge_raw[gi] = (SEL_RISE & rise) | (SEL_FALL & fall);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_q   <= '0;
            prev_q    <= '0;
            arm_cnt_q <= '0;
        end else begin
            stage_q   <= stage_d;
            prev_q    <= prev_d;
            arm_cnt_q <= arm_cnt_d;
        end
    end

    assign sync_out = sync_in;
    assign edge_out = armed ? edge_raw : '0;

endmodule

// File: rtl/nios_system_gpio_bidir.sv
// Parametrised Avalon-MM GPIO slave: output/direction registers with atomic
// set/clear, synchronised inputs, sticky edge capture and a maskable irq.
module nios_system_gpio_bidir
    import nios_system_gpio_pkg::*;
#(
    parameter int          DATA_WIDTH  = 16,
    parameter logic [31:0] RESET_OUT   = 32'd0,
    parameter logic [31:0] RESET_DIR   = 32'd0,
    parameter int          EDGE_TYPE   = EDGE_RISE,
    parameter int          IRQ_MODE    = IRQ_EDGE,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    nios_system_gpio_bidir_if.slave bus,
    input  logic [DATA_WIDTH-1:0]  in_port,
    output logic [DATA_WIDTH-1:0]  out_port,
    output logic [DATA_WIDTH-1:0]  oe_port,
    output logic                   irq
);

    if (!data_width_legal(DATA_WIDTH)) begin : g_bad_width
        $error("nios_system_gpio_bidir: DATA_WIDTH %0d outside 1..32", DATA_WIDTH);
    end
    if (!sync_stages_legal(SYNC_STAGES)) begin : g_bad_sync
        $error("nios_system_gpio_bidir: SYNC_STAGES %0d outside 2..4", SYNC_STAGES);
    end

    logic [DATA_WIDTH-1:0] sync_in;
    logic [DATA_WIDTH-1:0] edge_det;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] edge_clr;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  wr_en;
    logic                  unused_wdata;

    logic [DATA_WIDTH-1:0] out_q,     out_d;
    logic [DATA_WIDTH-1:0] dir_q,     dir_d;
    logic [DATA_WIDTH-1:0] mask_q,    mask_d;
    logic [DATA_WIDTH-1:0] edgecap_q, edgecap_d;
    logic [31:0]           readdata_q, readdata_d;

    nios_system_gpio_sync #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (in_port),
        .sync_out (sync_in),
        .edge_out (edge_det)
    );

    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign wdata        = bus.writedata[DATA_WIDTH-1:0];
    assign unused_wdata = ^bus.writedata;

    always_comb begin
        out_d    = out_q;
        dir_d    = dir_q;
        mask_d   = mask_q;
        edge_clr = '0;
        if (wr_en) begin
            unique case (bus.address)
                ADDR_DATA:    out_d    = wdata;
                ADDR_DIR:     dir_d    = wdata;
                ADDR_IRQMASK: mask_d   = wdata;
                ADDR_EDGECAP: edge_clr = wdata;
                ADDR_OUTSET:  out_d    = out_q | wdata;
                ADDR_OUTCLR:  out_d    = out_q & ~wdata;
                default:      ;
            endcase
        end
        // A fresh edge outranks a same-cycle write-1-clear.
        edgecap_d = edge_det | (edgecap_q & ~edge_clr);
    end

    always_comb begin
        rd_word = '0;
        unique case (bus.address)
            ADDR_DATA:    rd_word = sync_in;
            ADDR_DIR:     rd_word = dir_q;
            ADDR_IRQMASK: rd_word = mask_q;
            ADDR_EDGECAP: rd_word = edgecap_q;
            default:      rd_word = '0;
        endcase
        readdata_d                 = '0;
        readdata_d[DATA_WIDTH-1:0] = rd_word;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q      <= RESET_OUT[DATA_WIDTH-1:0];
            dir_q      <= RESET_DIR[DATA_WIDTH-1:0];
            mask_q     <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
        end else begin
            out_q      <= out_d;
            dir_q      <= dir_d;
            mask_q     <= mask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign out_port     = out_q;
    assign oe_port      = dir_q;

    // irq sees only registered state, never the raw pads.
    if (IRQ_MODE == IRQ_EDGE) begin : g_irq_edge
        assign irq = |(edgecap_q & mask_q);
    end else begin : g_irq_level
        assign irq = |(sync_in & mask_q);
    end

endmodule
